// File: rtl/t_ff_bank.sv
// t_ff_bank: WIDTH-bit T flip-flop bank with toggle, up/down count and load.
// Up/down counting uses an internal synchronous T-FF toggle chain.
module t_ff_bank #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic [WIDTH-1:0] tv_up;
  logic [WIDTH-1:0] tv_dn;
  logic             all_ones;
  logic             all_zero;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  mode_e            mode_s;

  assign mode_s   = mode_e'(mode);
  assign all_ones = &q_r;
  assign all_zero = ~|q_r;

  // Toggle chains: bit i flips when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    tv_up    = '0;
    tv_dn    = '0;
    tv_up[0] = 1'b1;
    tv_dn[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      tv_up[i] = tv_up[i-1] & q_r[i-1];
      tv_dn[i] = tv_dn[i-1] & ~q_r[i-1];
    end
  end

  // Next-state and terminal-count selection per mode
  always_comb begin
    q_nxt  = q_r;
    tc_nxt = 1'b0;
    if (e) begin
      unique case (mode_s)
        MODE_TOGGLE: begin
          q_nxt = q_r ^ t;
        end
        MODE_UP: begin
          if (all_ones) begin
            tc_nxt = 1'b1;
            q_nxt  = SATURATE ? q_r : (q_r ^ tv_up);
          end else begin
            q_nxt = q_r ^ tv_up;
          end
        end
        MODE_DOWN: begin
          if (all_zero) begin
            tc_nxt = 1'b1;
            q_nxt  = SATURATE ? q_r : (q_r ^ tv_dn);
          end else begin
            q_nxt = q_r ^ tv_dn;
          end
        end
        MODE_LOAD: begin
          q_nxt = d;
        end
        default: begin
          q_nxt = q_r;
        end
      endcase
    end
  end

  // State register with synchronous reset; tc is a registered pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r  <= RESET_VAL;
      tc_r <= 1'b0;
    end else begin
      q_r  <= q_nxt;
      tc_r <= tc_nxt;
    end
  end

  assign q  = q_r;
  assign qn = ~q_r;
  assign tc = tc_r;

endmodule

// File: tb/tb_t_ff_bank.sv
// tb_t_ff_bank: scoreboard bench over four t_ff_bank configurations.
// All instances share one stimulus bus; a reference model predicts each.
module tb_t_ff_bank;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       e;
  logic [1:0] mode;
  logic [7:0] t_in;
  logic [7:0] d_in;

  logic [3:0] q0, qn0;
  logic [3:0] q1, qn1;
  logic [0:0] q2, qn2;
  logic [7:0] q3, qn3;
  logic       tc0, tc1, tc2, tc3;

  logic [7:0] qv  [N];
  logic [7:0] qnv [N];
  logic       tcv [N];

  int          cfg_w   [N] = '{4, 4, 1, 8};
  logic [7:0]  cfg_rv  [N] = '{8'h0A, 8'h00, 8'h01, 8'h00};
  bit          cfg_sat [N] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic [7:0] mq [N];

  typedef struct {
    int         idx;
    logic [7:0] q;
    logic       tc;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  t_ff_bank #(.WIDTH(4), .RESET_VAL(4'hA), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst(rst), .e(e), .mode(mode),
    .t(t_in[3:0]), .d(d_in[3:0]), .q(q0), .qn(qn0), .tc(tc0)
  );

  t_ff_bank #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst), .e(e), .mode(mode),
    .t(t_in[3:0]), .d(d_in[3:0]), .q(q1), .qn(qn1), .tc(tc1)
  );

  t_ff_bank #(.WIDTH(1), .RESET_VAL(1'b1), .SATURATE(1'b0)) u2 (
    .clk(clk), .rst(rst), .e(e), .mode(mode),
    .t(t_in[0:0]), .d(d_in[0:0]), .q(q2), .qn(qn2), .tc(tc2)
  );

  t_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SATURATE(1'b0)) u3 (
    .clk(clk), .rst(rst), .e(e), .mode(mode),
    .t(t_in), .d(d_in), .q(q3), .qn(qn3), .tc(tc3)
  );

  assign qv[0]  = {4'h0, q0};
  assign qv[1]  = {4'h0, q1};
  assign qv[2]  = {7'h0, q2};
  assign qv[3]  = q3;
  assign qnv[0] = {4'h0, qn0};
  assign qnv[1] = {4'h0, qn1};
  assign qnv[2] = {7'h0, qn2};
  assign qnv[3] = qn3;
  assign tcv[0] = tc0;
  assign tcv[1] = tc1;
  assign tcv[2] = tc2;
  assign tcv[3] = tc3;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] wmask(input int w);
    return 8'((9'h1 << w) - 9'h1);
  endfunction

  // Reference: plain arithmetic, independent of any toggle chain
  function automatic exp_t model(input int i, input logic r,
      input logic en, input logic [1:0] m,
      input logic [7:0] tt, input logic [7:0] dd);
    exp_t x;
    logic [7:0] mk;
    mk   = wmask(cfg_w[i]);
    x.idx = i;
    x.tc  = 1'b0;
    x.q   = mq[i];
    if (r) begin
      x.q = cfg_rv[i] & mk;
    end else if (en) begin
      case (m)
        2'b00: x.q = (mq[i] ^ tt) & mk;
        2'b01: begin
          if (mq[i] == mk) begin
            x.tc = 1'b1;
            x.q  = cfg_sat[i] ? mk : 8'h00;
          end else begin
            x.q = mq[i] + 8'h01;
          end
        end
        2'b10: begin
          if (mq[i] == 8'h00) begin
            x.tc = 1'b1;
            x.q  = cfg_sat[i] ? 8'h00 : mk;
          end else begin
            x.q = mq[i] - 8'h01;
          end
        end
        default: x.q = dd & mk;
      endcase
    end
    return x;
  endfunction

  task automatic cyc(input logic r, input logic en, input logic [1:0] m,
                     input logic [7:0] tt, input logic [7:0] dd);
    exp_t x;
    rst  = r;
    e    = en;
    mode = m;
    t_in = tt;
    d_in = dd;
    for (int i = 0; i < N; i++) begin
      x = model(i, r, en, m, tt, dd);
      sb.push_back(x);
      mq[i] = x.q;
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk($sformatf("q%0d", x.idx), {24'h0, qv[x.idx]}, {24'h0, x.q});
      chk($sformatf("qn%0d", x.idx), {24'h0, qnv[x.idx]},
          {24'h0, ~x.q & wmask(cfg_w[x.idx])});
      chk($sformatf("tc%0d", x.idx), {31'h0, tcv[x.idx]}, {31'h0, x.tc});
    end
  endtask

  localparam logic [1:0] TG = 2'b00;
  localparam logic [1:0] UP = 2'b01;
  localparam logic [1:0] DN = 2'b10;
  localparam logic [1:0] LD = 2'b11;

  int pulses;

  initial begin
    rst  = 1'b0;
    e    = 1'b0;
    mode = TG;
    t_in = '0;
    d_in = '0;
    for (int i = 0; i < N; i++) mq[i] = 'x;
    @(negedge clk);

    // reset with e=1 and UP, then release
    cyc(1, 1, UP, 8'h00, 8'h00);
    cyc(1, 1, UP, 8'hFF, 8'hFF);
    cyc(0, 1, UP, 8'h00, 8'h00);

    // toggle / hold
    cyc(0, 1, LD, 8'h00, 8'h00);
    cyc(0, 1, TG, 8'h05, 8'h00);
    cyc(0, 1, TG, 8'h05, 8'h00);
    cyc(0, 1, TG, 8'h0A, 8'h00);
    repeat (3) cyc(0, 0, TG, 8'hFF, 8'h00);
    repeat (2) cyc(0, 0, UP, 8'h00, 8'h00);

    // up wrap
    cyc(0, 1, LD, 8'h00, 8'h0E);
    repeat (3) cyc(0, 1, UP, 8'h00, 8'h00);

    // down saturate then up
    cyc(0, 1, LD, 8'h00, 8'h01);
    repeat (3) cyc(0, 1, DN, 8'h00, 8'h00);
    cyc(0, 1, UP, 8'h00, 8'h00);

    // up saturate on all-ones
    cyc(0, 1, LD, 8'h00, 8'h0F);
    repeat (3) cyc(0, 1, UP, 8'h00, 8'h00);
    cyc(0, 1, DN, 8'h00, 8'h00);

    // count, reverse, abort with reset
    cyc(0, 1, LD, 8'h00, 8'h00);
    repeat (5) cyc(0, 1, UP, 8'h00, 8'h00);
    cyc(0, 1, DN, 8'h00, 8'h00);
    cyc(0, 1, UP, 8'h00, 8'h00);
    cyc(0, 1, DN, 8'h00, 8'h00);
    cyc(1, 1, UP, 8'h00, 8'h00);
    cyc(0, 1, DN, 8'h00, 8'h00);

    // down wrap from zero
    cyc(0, 1, LD, 8'h00, 8'h00);
    repeat (2) cyc(0, 1, DN, 8'h00, 8'h00);

    // wide sweep: 256 ups give one tc pulse on the 8-bit bank
    cyc(0, 1, LD, 8'h00, 8'h00);
    pulses = 0;
    for (int k = 0; k < 256; k++) begin
      cyc(0, 1, UP, 8'h00, 8'h00);
      if (tc3 === 1'b1) pulses++;
    end
    chk("pulses8", pulses, 1);
    chk("q8_end", {24'h0, q3}, 32'h0);

    // random mix
    for (int k = 0; k < 60; k++) begin
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
